// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush arbitration for memory waits, the
// multi-cycle divider, load-use and branch-operand hazards, plus operand forwarding.

module hazard_fwd_lane (
    input  logic       rst,
    input  logic [4:0] srcE,
    input  logic [4:0] srcD,
    input  logic       regWriteM,
    input  logic [4:0] writeRegM,
    input  logic       regWriteW,
    input  logic [4:0] writeRegW,
    output logic [1:0] fwdE,
    output logic       fwdD
);
    logic hitM_E, hitW_E, hitM_D;

    assign hitM_E = regWriteM && (writeRegM != 5'd0) && (writeRegM == srcE);
    assign hitW_E = regWriteW && (writeRegW != 5'd0) && (writeRegW == srcE);
    assign hitM_D = regWriteM && (writeRegM != 5'd0) && (writeRegM == srcD);

    // M stage is the younger producer, so it wins over W
    always_comb begin
        fwdE = 2'b00;
        fwdD = 1'b0;
        if (rst) begin
            if (hitM_E)      fwdE = 2'b10;
            else if (hitW_E) fwdE = 2'b01;
            fwdD = hitM_D;
        end
    end
endmodule

module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeRegE,
    input  logic [4:0]  writeRegM,
    input  logic [4:0]  writeRegW,
    input  logic        regWriteE,
    input  logic        regWriteM,
    input  logic        regWriteW,
    input  logic        memToRegE,
    input  logic        memToRegM,
    input  logic        branchD,
    input  logic        jumpRegD,
    input  logic        pcSrcD,
    input  logic        divStartE,
    input  logic        divDoneE,
    input  logic        memReqM,
    input  logic        memAckM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic        divTimeout,
    output logic [15:0] stallCnt
);
    localparam int NUM_OPS = 2;

    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] DIV_WAIT = 2'b01;
    localparam logic [1:0] MEM_WAIT = 2'b10;

    logic [1:0] state, stateNxt;
    logic [5:0] wdog;
    logic       wdogExpire;
    logic       memStall, divStall, lwStall, brStall;
    logic       hitE_D, hitM_D;

    logic [NUM_OPS-1:0][4:0] srcE, srcD;
    logic [NUM_OPS-1:0][1:0] fwdE;
    logic [NUM_OPS-1:0]      fwdD;

    assign srcE = {rtE, rsE};
    assign srcD = {rtD, rsD};

    generate
        for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
            hazard_fwd_lane u_lane (
                .rst       (rst),
                .srcE      (srcE[i]),
                .srcD      (srcD[i]),
                .regWriteM (regWriteM),
                .writeRegM (writeRegM),
                .regWriteW (regWriteW),
                .writeRegW (writeRegW),
                .fwdE      (fwdE[i]),
                .fwdD      (fwdD[i])
            );
        end
    endgenerate

    assign forwardAE = fwdE[0];
    assign forwardBE = fwdE[1];
    assign forwardAD = fwdD[0];
    assign forwardBD = fwdD[1];

    assign hitE_D  = regWriteE && (writeRegE != 5'd0) && (writeRegE == rsD || writeRegE == rtD);
    assign hitM_D  = memToRegM && (writeRegM != 5'd0) && (writeRegM == rsD || writeRegM == rtD);
    assign lwStall = memToRegE && hitE_D;
    assign brStall = (branchD || jumpRegD) && (hitE_D || hitM_D);

    assign memStall = (state == MEM_WAIT && !memAckM) ||
                      (state == RUN && memReqM && !memAckM);
    assign divStall = (state == DIV_WAIT && !divDoneE) ||
                      (state == RUN && divStartE && !divDoneE);

    assign wdogExpire = (state == DIV_WAIT) && (wdog == 6'd63) && !divDoneE;

    always_comb begin
        stateNxt = state;
        case (state)
            RUN: begin
                if (memReqM && !memAckM)        stateNxt = MEM_WAIT;
                else if (divStartE && !divDoneE) stateNxt = DIV_WAIT;
            end
            DIV_WAIT: if (divDoneE || wdogExpire) stateNxt = RUN;
            MEM_WAIT: if (memAckM)                stateNxt = RUN;
            default:  stateNxt = RUN;
        endcase
    end

    // Priority chain: each level overrides all lower-priority controls
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (!rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (memStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (divStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwStall || brStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else begin
            flushD = pcSrcD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            wdog       <= 6'd0;
            divTimeout <= 1'b0;
            stallCnt   <= 16'd0;
        end else begin
            state <= stateNxt;
            // Held at zero outside DIV_WAIT so each wait starts a fresh count
            if (state == DIV_WAIT) wdog <= wdog + 6'd1;
            else                   wdog <= 6'd0;
            if (wdogExpire) divTimeout <= 1'b1;
            if (stallF && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.

module tb_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rst;
    logic [4:0]  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic        regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic        branchD, jumpRegD, pcSrcD, divStartE, divDoneE, memReqM, memAckM;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushM;
    logic [1:0]  forwardAE, forwardBE;
    logic        forwardAD, forwardBD, divTimeout;
    logic [15:0] stallCnt;
    logic [6:0]  ctrl;
    logic [5:0]  fwd;

    assign ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushM};
    assign fwd  = {forwardAE, forwardBE, forwardAD, forwardBD};

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .branchD(branchD), .jumpRegD(jumpRegD), .pcSrcD(pcSrcD),
        .divStartE(divStartE), .divDoneE(divDoneE), .memReqM(memReqM), .memAckM(memAckM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .divTimeout(divTimeout), .stallCnt(stallCnt)
    );

    task automatic idle();
        rst = 1'b1;
        {rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW} = '0;
        {regWriteE, regWriteM, regWriteW, memToRegE, memToRegM} = '0;
        {branchD, jumpRegD, pcSrcD, divStartE, divDoneE, memReqM, memAckM} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] model_ctrl(input bit inMem, input bit inDiv);
        bit lw, br, mems, divs, hitE, hitM;
        hitE = regWriteE && writeRegE != 0 && (writeRegE == rsD || writeRegE == rtD);
        hitM = memToRegM && writeRegM != 0 && (writeRegM == rsD || writeRegM == rtD);
        lw   = memToRegE && hitE;
        br   = (branchD || jumpRegD) && (hitE || hitM);
        mems = inMem ? !memAckM : (!inDiv && memReqM && !memAckM);
        divs = inDiv ? !divDoneE : (!inMem && divStartE && !divDoneE);
        if (!rst)     return 7'b0000111;
        if (mems)     return 7'b1111000;
        if (divs)     return 7'b1110001;
        if (lw || br) return 7'b1100010;
        return {4'b0000, pcSrcD, 2'b00};
    endfunction

    function automatic logic [1:0] model_fwde(input logic [4:0] s);
        if (!rst) return 2'b00;
        if (regWriteM && writeRegM != 0 && writeRegM == s) return 2'b10;
        if (regWriteW && writeRegW != 0 && writeRegW == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic model_fwdd(input logic [4:0] s);
        return rst && regWriteM && writeRegM != 0 && writeRegM == s;
    endfunction

    // ---------------- directed tests ----------------
    task automatic test_reset();
        idle();
        rst = 1'b0;
        regWriteM = 1'b1; writeRegM = 5'd3; rsE = 5'd3; rsD = 5'd3;
        memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd3;
        tick();
        n_checks++;
        if (ctrl !== 7'b0000111) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000111", ctrl); end
        n_checks++;
        if (fwd !== 6'b0) begin n_fail++; $display("FAIL reset_fwd got %b want 000000", fwd); end
        n_checks++;
        if (stallCnt !== 16'd0 || divTimeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs got cnt=%0d to=%b want 0/0", stallCnt, divTimeout);
        end
        idle();
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd5; rsD = 5'd5;
        #1;
        n_checks++;
        if (ctrl !== 7'b1100010) begin n_fail++; $display("FAIL load_use got %b want 1100010", ctrl); end
        tick();
        idle();
        #1;
        n_checks++;
        if (ctrl !== 7'b0 || stallCnt !== 16'd1) begin
            n_fail++; $display("FAIL load_use_after got ctrl=%b cnt=%0d want 0000000/1", ctrl, stallCnt);
        end
        memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd0; rsD = 5'd0;
        #1;
        n_checks++;
        if (ctrl !== 7'b0) begin n_fail++; $display("FAIL load_use_r0 got %b want 0000000", ctrl); end
        idle();
    endtask

    task automatic test_forward();
        do_reset();
        regWriteM = 1'b1; writeRegM = 5'd3; regWriteW = 1'b1; writeRegW = 5'd3; rsE = 5'd3;
        #1;
        n_checks++;
        if (forwardAE !== 2'b10) begin n_fail++; $display("FAIL fwd_m got %b want 10", forwardAE); end
        writeRegM = 5'd0;
        #1;
        n_checks++;
        if (forwardAE !== 2'b01) begin n_fail++; $display("FAIL fwd_w got %b want 01", forwardAE); end
        rsE = 5'd0;
        #1;
        n_checks++;
        if (forwardAE !== 2'b00) begin n_fail++; $display("FAIL fwd_r0 got %b want 00", forwardAE); end
        writeRegM = 5'd7; rtE = 5'd7; rsD = 5'd7; rtD = 5'd7; writeRegW = 5'd9; rsE = 5'd9;
        #1;
        n_checks++;
        if (fwd !== 6'b01_10_1_1) begin n_fail++; $display("FAIL fwd_mix got %b want 011011", fwd); end
        idle();
    endtask

    task automatic test_divide();
        do_reset();
        divStartE = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (ctrl !== 7'b1110001) begin n_fail++; $display("FAIL div_stall c=%0d got %b want 1110001", c, ctrl); end
            tick();
            divStartE = 1'b0;
        end
        divDoneE = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 7'b0) begin n_fail++; $display("FAIL div_done got %b want 0000000", ctrl); end
        tick();
        idle();
        #1;
        n_checks++;
        if (ctrl !== 7'b0 || divTimeout !== 1'b0 || stallCnt !== 16'd4) begin
            n_fail++; $display("FAIL div_after got ctrl=%b to=%b cnt=%0d want 0/0/4", ctrl, divTimeout, stallCnt);
        end
        divStartE = 1'b1; divDoneE = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 7'b0) begin n_fail++; $display("FAIL div_sameCycle got %b want 0000000", ctrl); end
        tick();
        idle();
        #1;
        n_checks++;
        if (ctrl !== 7'b0) begin n_fail++; $display("FAIL div_sameCycle_next got %b want 0000000", ctrl); end
    endtask

    task automatic test_watchdog();
        int bad = 0;
        do_reset();
        divStartE = 1'b1;
        tick();
        divStartE = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (stallF !== 1'b1 || divTimeout !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL wdog_wait bad_cycles=%0d want 0", bad); end
        #1;
        n_checks++;
        if (ctrl !== 7'b0 || divTimeout !== 1'b1 || stallCnt !== 16'd65) begin
            n_fail++; $display("FAIL wdog_expire got ctrl=%b to=%b cnt=%0d want 0/1/65", ctrl, divTimeout, stallCnt);
        end
    endtask

    task automatic test_mem_vs_div();
        do_reset();
        memReqM = 1'b1; divStartE = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 7'b1111000) begin n_fail++; $display("FAIL mem_div got %b want 1111000", ctrl); end
        tick();
        memReqM = 1'b0; divStartE = 1'b0; pcSrcD = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 7'b1111000) begin n_fail++; $display("FAIL mem_wait got %b want 1111000", ctrl); end
        memAckM = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 7'b0000100) begin n_fail++; $display("FAIL mem_ack got %b want 0000100", ctrl); end
        tick();
        idle();
        #1;
        n_checks++;
        if (ctrl !== 7'b0) begin n_fail++; $display("FAIL mem_run got %b want 0000000", ctrl); end
    endtask

    task automatic test_branch();
        do_reset();
        pcSrcD = 1'b1;
        #1;
        n_checks++;
        if (flushD !== 1'b1 || stallD !== 1'b0) begin n_fail++; $display("FAIL br_flush got fD=%b sD=%b want 1/0", flushD, stallD); end
        memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd4; rtD = 5'd4;
        #1;
        n_checks++;
        if (flushD !== 1'b0 || stallD !== 1'b1) begin n_fail++; $display("FAIL br_lw got fD=%b sD=%b want 0/1", flushD, stallD); end
        idle();
        branchD = 1'b1; memToRegM = 1'b1; writeRegM = 5'd6; rtD = 5'd6;
        #1;
        n_checks++;
        if (ctrl !== 7'b1100010) begin n_fail++; $display("FAIL br_memM got %b want 1100010", ctrl); end
        idle();
        jumpRegD = 1'b1; regWriteE = 1'b1; writeRegE = 5'd2; rsD = 5'd2;
        #1;
        n_checks++;
        if (ctrl !== 7'b1100010) begin n_fail++; $display("FAIL jr_aluE got %b want 1100010", ctrl); end
        idle();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        divStartE = 1'b1;
        tick();
        divStartE = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 7'b0000111) begin n_fail++; $display("FAIL rst_mid_ctrl got %b want 0000111", ctrl); end
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 7'b0 || stallCnt !== 16'd0) begin
            n_fail++; $display("FAIL rst_mid_after got ctrl=%b cnt=%0d want 0/0", ctrl, stallCnt);
        end
    endtask

    // ---------------- randomized run vs model ----------------
    task automatic test_random();
        bit mMem = 0, mDiv = 0, mTo = 0;
        int mSpent = 0, mCnt = 0;
        logic [6:0] expC;
        logic [5:0] expF;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst       = ($urandom_range(0, 149) != 0);
            rsD       = 5'($urandom_range(0, 3));
            rtD       = 5'($urandom_range(0, 3));
            rsE       = 5'($urandom_range(0, 3));
            rtE       = 5'($urandom_range(0, 3));
            writeRegE = 5'($urandom_range(0, 3));
            writeRegM = 5'($urandom_range(0, 3));
            writeRegW = 5'($urandom_range(0, 3));
            {regWriteE, regWriteM, regWriteW, memToRegE, memToRegM} = 5'($urandom);
            branchD   = ($urandom_range(0, 3) == 0);
            jumpRegD  = ($urandom_range(0, 5) == 0);
            pcSrcD    = ($urandom_range(0, 2) == 0);
            divStartE = ($urandom_range(0, 7) == 0);
            divDoneE  = (cyc < 400) ? ($urandom_range(0, 7) == 0) : 1'b0;
            memReqM   = ($urandom_range(0, 9) == 0);
            memAckM   = ($urandom_range(0, 2) == 0);
            #1;
            expC = model_ctrl(mMem, mDiv);
            expF = {model_fwde(rsE), model_fwde(rtE), model_fwdd(rsD), model_fwdd(rtD)};
            n_checks++;
            if (ctrl !== expC) begin n_fail++; $display("FAIL rand_ctrl cyc=%0d got %b want %b", cyc, ctrl, expC); end
            n_checks++;
            if (fwd !== expF) begin n_fail++; $display("FAIL rand_fwd cyc=%0d got %b want %b", cyc, fwd, expF); end
            n_checks++;
            if (divTimeout !== mTo) begin n_fail++; $display("FAIL rand_timeout cyc=%0d got %b want %b", cyc, divTimeout, mTo); end
            n_checks++;
            if (stallCnt !== 16'(mCnt)) begin n_fail++; $display("FAIL rand_cnt cyc=%0d got %0d want %0d", cyc, stallCnt, mCnt); end
            if (!rst) begin
                mMem = 0; mDiv = 0; mTo = 0; mSpent = 0; mCnt = 0;
            end else begin
                if (expC[6] && mCnt < 65535) mCnt++;
                if (mMem) begin
                    if (memAckM) mMem = 0;
                end else if (mDiv) begin
                    mSpent++;
                    if (divDoneE) mDiv = 0;
                    else if (mSpent == 64) begin mDiv = 0; mTo = 1; end
                end else if (memReqM && !memAckM) begin
                    mMem = 1;
                end else if (divStartE && !divDoneE) begin
                    mDiv = 1; mSpent = 0;
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_forward();
        test_divide();
        test_watchdog();
        test_mem_vs_div();
        test_branch();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-002 SHALL have inputs rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW  in  5 each  register indices per stage.
REQ-003 SHALL have inputs regWriteE, regWriteM, regWriteW, memToRegE, memToRegM  in  1 each  stage write-enable and load flags.
REQ-004 SHALL have inputs branchD, jumpRegD, pcSrcD  in  1 each  branch present, register jump present, redirect taken.
REQ-005 SHALL have inputs divStartE, divDoneE, memReqM, memAckM  in  1 each  divider start/done and data-memory request/ack.
REQ-006 SHALL have outputs stallF, stallD, stallE, stallM, flushD, flushE, flushM  out  1 each  pipeline-register controls; stallD/flushD drive the IF/ID register.
REQ-007 SHALL have outputs forwardAE, forwardBE  out  2 each  (00 regfile, 01 W result, 10 M result); forwardAD, forwardBD  out  1 each  (1 = M result).
REQ-008 SHALL have outputs divTimeout  out  1  sticky divider watchdog flag; stallCnt  out  16  stall-cycle counter.

Function
REQ-009 SHALL implement FSM {RUN, DIV_WAIT, MEM_WAIT}, state registered on posedge clk.
REQ-010 RUN -> MEM_WAIT when memReqM=1 and memAckM=0; else RUN -> DIV_WAIT when divStartE=1 and divDoneE=0; else stay RUN.
REQ-011 MEM_WAIT -> RUN on memAckM=1; DIV_WAIT -> RUN on divDoneE=1 or watchdog expiry.
REQ-012 Watchdog: 6-bit counter cleared on entering DIV_WAIT, incremented each DIV_WAIT cycle; on value 63 with divDoneE=0, SHALL set divTimeout=1 and return to RUN next cycle.
REQ-013 memStall = (state=MEM_WAIT and memAckM=0) or (state=RUN and memReqM and !memAckM); memStall SHALL force stallF=stallD=stallE=stallM=1, all flushes 0.
REQ-014 divStall = (state=DIV_WAIT and divDoneE=0) or (state=RUN and divStartE and !divDoneE); when divStall and !memStall: stallF=stallD=stallE=1, flushM=1, stallM=0.
REQ-015 lwStall = memToRegE and regWriteE and writeRegE!=0 and writeRegE in {rsD, rtD}.
REQ-016 brStall = (branchD or jumpRegD) and [ (regWriteE and writeRegE!=0 and writeRegE in {rsD,rtD}) or (memToRegM and writeRegM!=0 and writeRegM in {rsD,rtD}) ].
REQ-017 When (lwStall or brStall) and no mem/div stall: stallF=stallD=1, flushE=1, others 0.
REQ-018 flushD SHALL be pcSrcD and !stallD; the redirect is ignored while D is stalled.
REQ-019 Priority SHALL be memStall > divStall > lwStall/brStall > flushD; lower-priority outputs forced 0 when a higher one is active, except forwarding.
REQ-020 forwardAE = 10 if regWriteM and writeRegM!=0 and writeRegM=rsE; else 01 if regWriteW and writeRegW!=0 and writeRegW=rsE; else 00; forwardBE same using rtE.
REQ-021 forwardAD = regWriteM and writeRegM!=0 and writeRegM=rsD; forwardBD same using rtD.
REQ-022 Stall/flush/forward outputs SHALL be combinational from state and inputs (same-cycle effect).
REQ-023 stallCnt SHALL increment on each posedge where stallF=1, saturating at 16'hFFFF.
REQ-024 divStartE with divDoneE=1 in the same RUN cycle SHALL cause no stall and no transition.

Reset
REQ-025 rst=0 at posedge SHALL set state=RUN, watchdog=0, divTimeout=0, stallCnt=0.
REQ-026 While rst=0, all stalls and forwards SHALL be 0, flushD=flushE=flushM=1; reset mid-DIV_WAIT or MEM_WAIT SHALL abandon the wait.

Verification
REQ-027 Load-use: memToRegE=1, regWriteE=1, writeRegE=5, rsD=5 -> stallF=stallD=flushE=1 for one cycle; stallCnt +1.
REQ-028 Forward: regWriteM=1, writeRegM=3, regWriteW=1, writeRegW=3, rsE=3 -> forwardAE=10; writeRegM=0 instead -> forwardAE=01; rsE=0 -> 00.
REQ-029 Divide: divStartE=1, divDoneE asserted 4 cycles later -> stallF/D/E=1, flushM=1 for 4 cycles, RUN on 5th; divTimeout stays 0.
REQ-030 Watchdog: divStartE=1, divDoneE never -> DIV_WAIT 64 cycles, divTimeout=1, back to RUN, stalls drop.
REQ-031 Memory vs divide: memReqM=1, memAckM=0, divStartE=1 -> all four stalls=1, flushM=0, state MEM_WAIT; memAckM=1 -> RUN.
REQ-032 Branch: pcSrcD=1 with no hazard -> flushD=1; pcSrcD=1 with lwStall -> flushD=0, stallD=1.
